// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: opcodes, bundle kinds, FSM states.
package rv_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        K_R   = 2'b00,
        K_LW  = 2'b01,
        K_SW  = 2'b10,
        K_BEQ = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_WRITE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational packer: instruction fields to a 32-bit RV32I word (R, lw, sw, beq only).
module rv_instr_pack
    import rv_enc_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [12:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (kind_e'(kind))
            K_R:   word = {funct7, rs2, rs1, funct3, rd, OP_R};
            K_LW:  word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            K_SW:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            K_BEQ: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/rv_instr_enc.sv
// Sequential instruction encoder / imem loader: one bundle per 2 cycles to consecutive addresses.
// Define RV_ENC_CHECK_EN to enable the sticky immediate-range error flag.
module rv_instr_enc
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    state_e            state, nstate;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;
    logic [31:0]       enc;
    logic              hs;

    rv_instr_pack u_pack (
        .kind   (in_kind),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (enc)
    );

    assign hs = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nstate;
    end

    // Last address reached ends the load even without in_last; the pointer never wraps into use.
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE, S_DONE: if (start) nstate = S_LOAD;
            S_LOAD:         if (in_valid) nstate = S_WRITE;
            S_WRITE:        nstate = (last_q || (&ptr)) ? S_DONE : S_LOAD;
            default:        nstate = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state == S_LOAD) || (state == S_WRITE);
        done     = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            count      <= '0;
            last_q     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    ptr   <= '0;
                    count <= '0;
                end
                S_LOAD: if (hs) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc;
                    last_q     <= in_last;
                end
                S_WRITE: begin
                    imem_we <= 1'b0;
                    ptr     <= ptr + ADDR_W'(1);
                    count   <= count + (ADDR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef RV_ENC_CHECK_EN
    logic bad;
    assign bad = ((in_kind == K_BEQ) && in_imm[0]) ||
                 (((in_kind == K_LW) || (in_kind == K_SW)) && (in_imm[12] != in_imm[11]));

    always_ff @(posedge clk) begin
        if (reset)                                                   err <= 1'b0;
        else if (start && (state == S_IDLE || state == S_DONE))      err <= 1'b0;
        else if (hs && bad)                                          err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_instr_enc.sv
// Randomized self-checking bench for rv_instr_enc against an arithmetic encoding model.
module tb_rv_instr_enc;

    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_last;
    logic          in_ready, imem_we, busy, done, err;
    logic [1:0]    in_kind;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [12:0]   in_imm;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    int errors = 0;
    int checks = 0;
    int exp_ptr = 0;
    int exp_cnt = 0;
    bit exp_err = 0;

    rv_instr_enc #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Word built by positional arithmetic straight from the RV32I field layout.
    function automatic logic [31:0] ref_enc(input int k, input int rd, input int rs1, input int rs2,
                                            input int f3, input int f7, input int imm);
        longint w;
        longint base;
        base = longint'(rs1) * (64'd1 << 15) + longint'(f3) * (64'd1 << 12);
        case (k)
            0: w = longint'(f7) * (64'd1 << 25) + longint'(rs2) * (64'd1 << 20) + base
                   + longint'(rd) * 128 + 51;
            1: w = longint'(imm % 4096) * (64'd1 << 20) + base + longint'(rd) * 128 + 3;
            2: w = longint'((imm / 32) % 128) * (64'd1 << 25) + longint'(rs2) * (64'd1 << 20) + base
                   + longint'(imm % 32) * 128 + 35;
            default: w = longint'((imm / 4096) % 2) * (64'd1 << 31)
                   + longint'((imm / 32) % 64) * (64'd1 << 25) + longint'(rs2) * (64'd1 << 20) + base
                   + longint'((imm / 2) % 16) * 256 + longint'((imm / 2048) % 2) * 128 + 99;
        endcase
        return w[31:0];
    endfunction

    function automatic bit ref_bad(input int k, input int imm);
        if (k == 3) return (imm % 2) == 1;
        if (k == 1 || k == 2) return ((imm / 4096) % 2) != ((imm / 2048) % 2);
        return 1'b0;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_ptr = 0;
        exp_cnt = 0;
        exp_err = 0;
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_cnt", {25'b0, count}, 32'd0);
    endtask

    // Present one bundle (caller is at a negedge with the DUT in LOAD) and check the write it causes.
    task automatic send(input int k, input int rd, input int rs1, input int rs2, input int f3,
                        input int f7, input int imm, input bit last);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_kind = 2'(k); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = 13'(imm); in_last = last;
        @(negedge clk);
        in_valid = 1'b0;
        chk("we", {31'b0, imem_we}, 32'd1);
        chk("addr", {26'b0, imem_addr}, 32'(exp_ptr));
        chk("wdata", imem_wdata, ref_enc(k, rd, rs1, rs2, f3, f7, imm));
        chk("ready_in_write", {31'b0, in_ready}, 32'd0);
`ifdef RV_ENC_CHECK_EN
        if (ref_bad(k, imm)) exp_err = 1;
`endif
        @(negedge clk);
        exp_cnt++;
        chk("we_drop", {31'b0, imem_we}, 32'd0);
        chk("count", {25'b0, count}, 32'(exp_cnt));
        chk("done", {31'b0, done}, {31'b0, (last || exp_ptr == DEPTH - 1)});
        chk("err", {31'b0, err}, {31'b0, exp_err});
        exp_ptr++;
    endtask

    task automatic send_rand(input bit last);
        send($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 8191), last);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_addr", {26'b0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst_cnt_err", {24'b0, count, err}, 32'd0);

        // Directed program from known encodings.
        do_start();
        send(0, 3, 1, 2, 0, 0, 0, 0);
        chk("add_lit", imem_wdata, 32'h002081B3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored", {25'b0, count}, 32'd1);
        send(1, 5, 2, 0, 2, 0, 8, 0);
        chk("lw_lit", imem_wdata, 32'h00812283);
        send(2, 0, 2, 5, 2, 0, 12, 0);
        chk("sw_lit", imem_wdata, 32'h00512623);
        send(3, 0, 1, 2, 0, 0, 13'h1FF8, 1);
        chk("beq_lit", imem_wdata, 32'hFE208CE3);
        @(negedge clk);
        chk("done_hold", {30'b0, done, in_ready}, 32'd2);

        // Random programs with random idle gaps, each ended by in_last.
        for (int p = 0; p < 6; p++) begin
            int len = $urandom_range(1, 12);
            do_start();
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_rand(i == len - 1);
            end
        end

        // Fill to capacity without in_last; further bundles are refused.
        do_start();
        for (int i = 0; i < DEPTH; i++) send_rand(0);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem_we || in_ready) chk("no_accept_full", {30'b0, imem_we, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("full_cnt", {25'b0, count}, 32'(DEPTH));
        chk("full_done", {31'b0, done}, 32'd1);

`ifdef RV_ENC_CHECK_EN
        do_start();
        send(3, 0, 1, 2, 0, 0, 13'h005, 0);
        chk("err_beq", {31'b0, err}, 32'd1);
        send(0, 1, 1, 1, 0, 0, 0, 1);
        chk("err_sticky", {31'b0, err}, 32'd1);
        do_start();
        chk("err_clear", {31'b0, err}, 32'd0);
        send(1, 1, 1, 0, 0, 0, 13'h0800, 1);
        chk("err_lw_range", {31'b0, err}, 32'd1);
`endif

        // Reset during WRITE: the write is visible, then everything returns to reset values.
        do_start();
        in_valid = 1'b1; in_kind = 2'd0; in_rd = 5'd7; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_we", {31'b0, imem_we}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("wr_rst_we", {31'b0, imem_we}, 32'd0);
        chk("wr_rst_data", imem_wdata, 32'd0);
        chk("wr_rst_state", {29'b0, busy, done, in_ready}, 32'd0);
        chk("wr_rst_cnt", {25'b0, count}, 32'd0);
        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("rst_beats_start", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
